im_iw: RTL and testbench

Memory-stage controller and MEM/WB pipeline register. It consumes the EX/MEM register outputs, runs load/store accesses on a req/ack data-memory port, and stalls the upstream stages while an access is outstanding. It then presents the writeback bundle to the W stage. It sits between the EX/MEM register and the register-file write port.

---
 rtl/im_iw.sv | 143 ++++++++++++++
 tb/tb_im_iw.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_iw.sv
// Memory-stage controller and MEM/WB pipeline register: issues word loads/stores on a req/ack port,
// stalls upstream while busy, then presents the writeback bundle. Optional abort via `MEM_TIMEOUT_EN.
module im_iw #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        RegWriteM,
    input  logic [31:0] AOE,
    input  logic [31:0] WDE,
    input  logic [4:0]  WAE,
    input  logic [31:0] PCE,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic [31:0] AOW,
    output logic [31:0] RDW,
    output logic [4:0]  WAW,
    output logic [31:0] PCW,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("im_iw: TIMEOUT must be in 2..255");
    end

    state_t      state;
    logic        memop;
    logic        hold_load;
    logic        hold_regwrite;
    logic [31:0] hold_ao;
    logic [31:0] hold_pc;
    logic [4:0]  hold_wa;

    assign memop = MemtoRegM | MemWriteM;

    // Depends only on state and the M-stage op, never on mem_ack.
    assign stallM = (state == BUSY) || ((state == IDLE) && memop);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            MemtoRegW     <= 1'b0;
            RegWriteW     <= 1'b0;
            AOW           <= 32'h0;
            RDW           <= 32'h0;
            WAW           <= 5'd0;
            PCW           <= 32'h0;
            hold_load     <= 1'b0;
            hold_regwrite <= 1'b0;
            hold_ao       <= 32'h0;
            hold_pc       <= 32'h0;
            hold_wa       <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= 8'd0;
            mem_err       <= 1'b0;
`endif
        end else begin
            // Bubble unless a branch below retires an instruction.
            MemtoRegW <= 1'b0;
            RegWriteW <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (memop) begin
                        hold_load     <= MemtoRegM;
                        hold_regwrite <= RegWriteM;
                        hold_ao       <= AOE;
                        hold_pc       <= PCE;
                        hold_wa       <= WAE;
                        mem_req       <= 1'b1;
                        mem_we        <= MemWriteM;
                        mem_addr      <= {AOE[31:2], 2'b00};
                        mem_wdata     <= WDE;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= 8'd0;
`endif
                        state         <= BUSY;
                    end else begin
                        MemtoRegW <= MemtoRegM;
                        RegWriteW <= RegWriteM && (WAE != 5'd0);
                        AOW       <= AOE;
                        RDW       <= 32'h0;
                        WAW       <= WAE;
                        PCW       <= PCE;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        MemtoRegW <= hold_load;
                        RegWriteW <= hold_regwrite && (hold_wa != 5'd0);
                        AOW       <= hold_ao;
                        RDW       <= hold_load ? mem_rdata : 32'h0;
                        WAW       <= hold_wa;
                        PCW       <= hold_pc;
                        state     <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LIMIT) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    // The completed op is still on the M inputs; skip it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_iw.sv
// Randomized self-checking bench for im_iw against an instruction-lifecycle model;
// honours `MEM_TIMEOUT_EN when the design is built with it.
module tb_im_iw;

    localparam int unsigned TO = 4;

    typedef struct {
        logic        m2r;
        logic        mw;
        logic        rw;
        logic [31:0] ao;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  wa;
        int          w;
        logic [31:0] rdata;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemtoRegM = 1'b0, MemWriteM = 1'b0, RegWriteM = 1'b0;
    logic [31:0] AOE = 32'h0, WDE = 32'h0, PCE = 32'h0;
    logic [4:0]  WAE = 5'd0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stallM, mem_req, mem_we, MemtoRegW, RegWriteW, mem_err;
    logic [31:0] mem_addr, mem_wdata, AOW, RDW, PCW;
    logic [4:0]  WAW;

    always #5 clk = ~clk;

    im_iw #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .AOE(AOE), .WDE(WDE), .WAE(WAE), .PCE(PCE),
        .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
        .AOW(AOW), .RDW(RDW), .WAW(WAW), .PCW(PCW), .mem_err(mem_err)
    );

    instr_t      prog[$];
    instr_t      cur;
    int          age = 0, bcyc = 0, cyc = 0;
    bit          done_f = 1'b0, started = 1'b0;
    logic        e_req = 0, e_we = 0, e_m2r = 0, e_rw = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ao = 0, e_rd = 0, e_pc = 0;
    logic [4:0]  e_wa = 0;
    int          checks = 0, failures = 0;
    int          load_st = 0, store_st = 0, req_rises = 0;
    logic        prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_mem(input instr_t i);
        return i.m2r | i.mw;
    endfunction

    function automatic bit m_busy();
        return is_mem(cur) && !done_f && age >= 1;
    endfunction

    function automatic instr_t mk(input logic m2r, input logic mw, input logic rw,
                                  input logic [31:0] ao, input logic [31:0] wd,
                                  input logic [4:0] wa, input logic [31:0] pc,
                                  input int w, input logic [31:0] rdata);
        instr_t i;
        i.m2r = m2r; i.mw = mw; i.rw = rw; i.ao = ao; i.wd = wd;
        i.wa = wa; i.pc = pc; i.w = w; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int kind;
        logic [4:0] wa;
        int w;
        kind = int'($urandom_range(0, 3));
        wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
`ifdef MEM_TIMEOUT_EN
        w = int'($urandom_range(0, 6));
`else
        w = int'($urandom_range(0, 4));
`endif
        case (kind)
            1: return mk(1'b1, 1'b0, 1'b1, $urandom, $urandom, wa, $urandom, w, $urandom);
            2: return mk(1'b0, 1'b1, 1'b0, $urandom, $urandom, wa, $urandom, w, $urandom);
            3: return mk(1'b0, 1'b0, 1'b0, $urandom, $urandom, wa, $urandom, 0, 32'h0);
            default: return mk(1'b0, 1'b0, 1'($urandom), $urandom, $urandom, wa, $urandom, 0, 32'h0);
        endcase
    endfunction

    task automatic retire(input instr_t i, input logic [31:0] rd);
        e_m2r = i.m2r;
        e_rw  = i.rw && (i.wa != 5'd0);
        e_ao  = i.ao;
        e_rd  = rd;
        e_wa  = i.wa;
        e_pc  = i.pc;
    endtask

    task automatic advance();
        cur = (prog.size() > 0) ? prog.pop_front() : rand_instr();
        age = 0;
        done_f = 1'b0;
        bcyc = 0;
    endtask

    // Model: each instruction retires one edge after it reaches M, or one edge after its ack.
    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_err = 0;
            e_m2r = 0; e_rw = 0; e_ao = 0; e_rd = 0; e_wa = 0; e_pc = 0;
            cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            age = 0; done_f = 1'b0; bcyc = 0; cyc = 0;
        end else begin
            cyc++;
            e_m2r = 1'b0; e_rw = 1'b0; e_err = 1'b0;
            if (!is_mem(cur)) begin
                retire(cur, 32'h0);
                advance();
            end else if (done_f) begin
                advance();
            end else if (age == 0) begin
                e_req = 1'b1;
                e_we = cur.mw;
                e_addr = cur.ao & 32'hFFFF_FFFC;
                e_wdata = cur.wd;
                age = 1;
                bcyc = 0;
            end else if (mem_ack) begin
                e_req = 1'b0;
                retire(cur, cur.m2r ? mem_rdata : 32'h0);
                done_f = 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (bcyc == int'(TO) - 1) begin
                e_req = 1'b0;
                e_err = 1'b1;
                done_f = 1'b1;
            end
`endif
            else begin
                bcyc++;
            end
        end
    end

    // Drive M inputs and the memory responder, then compare once things settle.
    always @(negedge clk) begin
        MemtoRegM = cur.m2r; MemWriteM = cur.mw; RegWriteM = cur.rw;
        AOE = cur.ao; WDE = cur.wd; WAE = cur.wa; PCE = cur.pc;
        if (m_busy()) begin
            mem_ack = (bcyc == cur.w);
            mem_rdata = cur.rdata;
        end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
        #1;
        if (started) begin
            chk("stallM", 32'(stallM), 32'(is_mem(cur) && !done_f));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("MemtoRegW", 32'(MemtoRegW), 32'(e_m2r));
            chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
            chk("AOW", AOW, e_ao);
            chk("RDW", RDW, e_rd);
            chk("WAW", 32'(WAW), 32'(e_wa));
            chk("PCW", PCW, e_pc);
            chk("mem_err", 32'(mem_err), 32'(e_err));
            if (!reset && $time < 200) begin
                if (stallM && cyc >= 2 && cyc <= 4) load_st++;
                if (stallM && cyc >= 5 && cyc <= 10) store_st++;
                if (mem_req && !prev_req && cyc >= 5 && cyc <= 10) req_rises++;
                case (cyc)
                    2: begin
                        chk("lit_alu_rw", 32'(RegWriteW), 32'h1);
                        chk("lit_alu_aow", AOW, 32'h0000_1234);
                        chk("lit_alu_waw", 32'(WAW), 32'd5);
                        chk("lit_alu_pcw", PCW, 32'h3000);
                    end
                    3: begin
                        chk("lit_ld_addr", mem_addr, 32'h104);
                        chk("lit_ld_we", 32'(mem_we), 32'h0);
                    end
                    4: begin
                        chk("lit_ld_rdw", RDW, 32'hDEAD_BEEF);
                        chk("lit_ld_m2r", 32'(MemtoRegW), 32'h1);
                        chk("lit_ld_rw", 32'(RegWriteW), 32'h1);
                        chk("lit_ld_waw", 32'(WAW), 32'd8);
                        chk("lit_ld_stall_cycles", 32'(load_st), 32'd2);
                    end
                    6: begin
                        chk("lit_st_we", 32'(mem_we), 32'h1);
                        chk("lit_st_addr", mem_addr, 32'h200);
                        chk("lit_st_wdata", mem_wdata, 32'h55AA_55AA);
                    end
                    9: chk("lit_st_wdata_hold", mem_wdata, 32'h55AA_55AA);
                    10: begin
                        chk("lit_st_rw", 32'(RegWriteW), 32'h0);
                        chk("lit_st_stall_cycles", 32'(store_st), 32'd5);
                        chk("lit_st_requests", 32'(req_rises), 32'd1);
                    end
                    14: begin
                        chk("lit_ld0_rw", 32'(RegWriteW), 32'h0);
                        chk("lit_ld0_m2r", 32'(MemtoRegW), 32'h1);
                    end
                    default: ;
                endcase
            end
            prev_req = mem_req;
        end
    end

    initial begin
        int budget;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        prog.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd5, 32'h3000, 0, 32'h0));
        prog.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0106, 32'h0, 5'd8, 32'h3004, 0, 32'hDEAD_BEEF));
        prog.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h55AA_55AA, 5'd3, 32'h3008, 3, 32'h1111_2222));
        prog.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd0, 32'h300C, 1, 32'hCAFE_F00D));
`ifdef MEM_TIMEOUT_EN
        prog.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 5'd9, 32'h3010, 255, 32'h0));
        prog.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0404, 32'h0, 5'd9, 32'h3014, 3, 32'h1234_5678));
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (1500) @(negedge clk);

        // Reset in the middle of an outstanding access.
        budget = 0;
        while (!m_busy() && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!m_busy()) begin
            failures++;
            $display("FAIL busy_wait got=idle expected=busy");
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_stallM", 32'(stallM), 32'h0);
        chk("rst_aow", AOW, 32'h0);
        chk("rst_regwritew", 32'(RegWriteW), 32'h0);
        reset = 1'b0;
        repeat (1500) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
